// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
//   fsm_state_e : control state derived from the history fill level
//   fill_width  : width of the fill counter for a given pattern length
package seq_detect_pkg;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } fsm_state_e;

    // Fill counts 0..pat_w-1, which always fits in clog2(pat_w) bits for pat_w >= 2.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w);
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear to zero (wins over inc_i)
//   inc_i        : count one event
//   cnt_o        : current count, sticks at all-ones
//   sat_o        : registered flag, high while cnt_o is all-ones
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sat_r;
    logic             sat_next_s;

    // Next count: clear first, then saturating increment.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr_i) begin
            cnt_next_s = '0;
        end else if (inc_i && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        sat_next_s = (cnt_next_s == CNT_MAX);
    end

    // Count and saturation flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            sat_r <= sat_next_s;
        end
    end

    assign cnt_o = cnt_r;
    assign sat_o = sat_r;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with loadable pattern,
// overlapping / non-overlapping mode and a saturating match counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i, x_i    : stream bit and its valid qualifier
//   overlap_i    : 1 = overlapping, 0 = non-overlapping detection
//   pat_ld_i     : load pat_i (MSB = oldest bit), restarts history
//   cnt_clr_i    : clear the match counter
//   y_o          : same-cycle match (combinational, Mealy)
//   match_cnt_o  : saturating match count
//   cnt_sat_o    : match count is all-ones
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             x_i,
    input  logic             overlap_i,
    input  logic             pat_ld_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             cnt_clr_i,
    output logic             y_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cnt_sat_o
);

    localparam int                FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;

    logic [PAT_W-1:0]  pat_next_s;
    logic [PAT_W-2:0]  hist_next_s;
    logic [FILL_W-1:0] fill_next_s;

    fsm_state_e        state_s;
    logic [PAT_W-1:0]  window_s;
    logic              match_s;

    // Match decision. A load cycle never matches, which also keeps pat_i off the y_o path.
    always_comb begin
        state_s  = (fill_r == FILL_LAST) ? ST_ARMED : ST_FILL;
        window_s = {hist_r, x_i};
        match_s  = en_i & ~pat_ld_i & (state_s == ST_ARMED) & (window_s == pat_r);
    end

    // Next pattern / history / fill: load beats accept, idle cycles hold.
    always_comb begin
        pat_next_s  = pat_r;
        hist_next_s = hist_r;
        fill_next_s = fill_r;
        if (pat_ld_i) begin
            pat_next_s  = pat_i;
            hist_next_s = '0;
            fill_next_s = '0;
        end else if (en_i) begin
            // Dropping the window MSB works for every PAT_W >= 2, including a 1-bit history.
            hist_next_s = window_s[PAT_W-2:0];
            if (match_s && !overlap_i) begin
                // History bits are kept but ignored until PAT_W-1 new bits arrive.
                fill_next_s = '0;
            end else if (fill_r != FILL_LAST) begin
                fill_next_s = fill_r + FILL_W'(1);
            end else begin
                fill_next_s = fill_r;
            end
        end else begin
            pat_next_s  = pat_r;
        end
    end

    // Detector state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pat_r  <= PATTERN;
            hist_r <= '0;
            fill_r <= '0;
        end else begin
            pat_r  <= pat_next_s;
            hist_r <= hist_next_s;
            fill_r <= fill_next_s;
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr_i),
        .inc_i (match_s),
        .cnt_o (match_cnt_o),
        .sat_o (cnt_sat_o)
    );

    assign y_o = match_s;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int PAT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             en_i;
    logic             x_i;
    logic             overlap_i;
    logic             pat_ld_i;
    logic [PAT_W-1:0] pat_i;
    logic             cnt_clr_i;

    logic             y_a;
    logic [7:0]       cnt_a;
    logic             sat_a;
    logic             y_b;
    logic [1:0]       cnt_b;
    logic             sat_b;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .x_i(x_i), .overlap_i(overlap_i),
        .pat_ld_i(pat_ld_i), .pat_i(pat_i), .cnt_clr_i(cnt_clr_i),
        .y_o(y_a), .match_cnt_o(cnt_a), .cnt_sat_o(sat_a)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .x_i(x_i), .overlap_i(overlap_i),
        .pat_ld_i(pat_ld_i), .pat_i(pat_i), .cnt_clr_i(cnt_clr_i),
        .y_o(y_b), .match_cnt_o(cnt_b), .cnt_sat_o(sat_b)
    );

    // Reference model: the bits accepted since the last restart, the pattern, two counts.
    bit               m_bits[$];
    logic [PAT_W-1:0] m_pat;
    int               m_cnt_a;
    int               m_cnt_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_bits.delete();
        m_pat   = 4'b1011;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endfunction

    // Match when the last PAT_W-1 remembered bits followed by x spell the pattern.
    function automatic logic model_match(input logic en, input logic x, input logic ld);
        int w;
        int n;
        if (!en || ld || m_bits.size() < PAT_W - 1) return 1'b0;
        n = m_bits.size();
        w = 0;
        for (int i = n - (PAT_W - 1); i < n; i++) w = w * 2 + int'(m_bits[i]);
        w = w * 2 + int'(x);
        return (w == int'(m_pat));
    endfunction

    function automatic void model_edge(input logic en, input logic x, input logic ov,
                                       input logic ld, input logic [PAT_W-1:0] p,
                                       input logic clr, input logic m);
        if (ld) begin
            m_pat = p;
            m_bits.delete();
        end else if (en) begin
            if (m && !ov) m_bits.delete();
            else begin
                m_bits.push_back(x);
                if (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
            end
        end
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (m) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
    endfunction

    task automatic check_counts();
        check("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
        check("sat_a", 32'(sat_a), 32'(m_cnt_a == 255));
        check("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
        check("sat_b", 32'(sat_b), 32'(m_cnt_b == 3));
    endtask

    task automatic step(input logic en, input logic x, input logic ov, input logic ld,
                        input logic [PAT_W-1:0] p, input logic clr);
        logic exp_y;
        @(negedge clk_i);
        en_i = en; x_i = x; overlap_i = ov; pat_ld_i = ld; pat_i = p; cnt_clr_i = clr;
        #1;
        exp_y = model_match(en, x, ld);
        check("y_a", 32'(y_a), 32'(exp_y));
        check("y_b", 32'(y_b), 32'(exp_y));
        @(posedge clk_i);
        #1;
        model_edge(en, x, ov, ld, p, clr, exp_y);
        check_counts();
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input logic ov);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], ov, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic restart(input logic [PAT_W-1:0] p);
        step(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b1);
    endtask

    // Reset asserted mid-cycle while en/x are still driven; outputs must drop at once.
    task automatic mid_reset(input logic en, input logic x);
        logic exp_y;
        @(negedge clk_i);
        en_i = en; x_i = x; pat_ld_i = 1'b0; cnt_clr_i = 1'b0;
        #1;
        exp_y = model_match(en, x, 1'b0);
        check("pre_rst_y", 32'(y_a), 32'(exp_y));
        #1;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("rst_y_a", 32'(y_a), 32'd0);
        check("rst_y_b", 32'(y_b), 32'd0);
        check_counts();
        @(negedge clk_i);
        en_i = 1'b0;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; x_i = 1'b0; overlap_i = 1'b1;
        pat_ld_i = 1'b0; pat_i = 4'b0000; cnt_clr_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_y", 32'(y_a), 32'd0);
        check_counts();
        @(negedge clk_i);
        rst_i = 1'b0;

        // Overlapping: matches on bits 4 and 7.
        feed(16'b1011011, 7, 1'b1);
        check("s1_cnt", 32'(cnt_a), 32'd2);

        // Non-overlapping: match on bit 4 only.
        restart(4'b1011);
        feed(16'b1011011, 7, 1'b0);
        check("s2_cnt", 32'(cnt_a), 32'd1);

        // Bubbles with x toggling while disabled.
        restart(4'b1011);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] s;
            s = 4'b1011;
            step(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            for (int k = 0; k < 3; k++) step(1'b0, k[0] ^ s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
        end
        check("s3_cnt", 32'(cnt_a), 32'd1);

        // Pattern load mid-stream; old pattern dead; load beats a would-be match.
        restart(4'b1011);
        feed(16'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        feed(16'b0110, 4, 1'b1);
        check("s4_cnt", 32'(cnt_a), 32'd1);
        feed(16'b1011, 4, 1'b1);
        check("s4_old", 32'(cnt_a), 32'd1);
        restart(4'b0110);
        feed(16'b011, 3, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
        check("s4_ldm", 32'(cnt_a), 32'd0);

        // Saturation of the 2-bit counter, then clear concurrent with a match.
        restart(4'b1011);
        feed(16'b1011011011011, 13, 1'b1);
        check("s5_cnt_b", 32'(cnt_b), 32'd3);
        check("s5_sat_b", 32'(sat_b), 32'd1);
        check("s5_cnt_a", 32'(cnt_a), 32'd4);
        feed(16'b01, 2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        check("s5_clr", 32'(cnt_a), 32'd0);

        // Async reset after 1,0,1 with the completing bit on x.
        restart(4'b1011);
        feed(16'b1011, 4, 1'b1);
        feed(16'b101, 3, 1'b1);
        mid_reset(1'b1, 1'b1);
        feed(16'b1, 1, 1'b1);
        check("s6_one", 32'(cnt_a), 32'd0);
        feed(16'b011, 3, 1'b1);
        check("s6_full", 32'(cnt_a), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 60) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
